// File: rtl/kernel_mult_pkg.sv
// Shared constants for the convolver kernel multiplier.
// Default geometry, lane count and the signed saturation limits used when
// the design is built with KERNEL_MULT_SATURATE_EN.
package kernel_mult_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_KERNEL_SIZE = 3;
  localparam int NUM_LANES           = DEFAULT_KERNEL_SIZE * DEFAULT_KERNEL_SIZE;

  // Widest lane these limits are defined for; limits are computed in a
  // double-width signed domain so they compare directly against full products.
  localparam int MAX_DATA_WIDTH = 64;

  // Largest signed value representable in dw bits, sign-extended.
  function automatic logic signed [2*MAX_DATA_WIDTH-1:0] sat_max(input int dw);
    return (128'sd1 <<< (dw - 1)) - 128'sd1;
  endfunction

  // Smallest signed value representable in dw bits, sign-extended.
  function automatic logic signed [2*MAX_DATA_WIDTH-1:0] sat_min(input int dw);
    return -(128'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/kernel_multiplier_lane.sv
// mult_lane: one signed DATA_WIDTH x DATA_WIDTH multiply, purely combinational.
// Default build keeps the low DATA_WIDTH bits of the product (wrap-around).
// With KERNEL_MULT_SATURATE_EN defined the full product is clamped to the
// signed DATA_WIDTH range instead.
module mult_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] i_weight,
  input  logic signed [DATA_WIDTH-1:0] i_pixel,
  output logic        [DATA_WIDTH-1:0] o_product
);

`ifdef KERNEL_MULT_SATURATE_EN
  import kernel_mult_pkg::*;

  localparam logic signed [2*DATA_WIDTH-1:0] P_MAX = (2*DATA_WIDTH)'(sat_max(DATA_WIDTH));
  localparam logic signed [2*DATA_WIDTH-1:0] P_MIN = (2*DATA_WIDTH)'(sat_min(DATA_WIDTH));

  logic signed [2*DATA_WIDTH-1:0] w_full;

  assign w_full = i_weight * i_pixel;

  // Clamp the full-precision product into the lane width.
  // NOTE: every branch assigns o_product, so no latch is inferred.
  always_comb begin
    o_product = w_full[DATA_WIDTH-1:0];
    if (w_full > P_MAX) begin
      o_product = P_MAX[DATA_WIDTH-1:0];
    end else if (w_full < P_MIN) begin
      o_product = P_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  // Low half of a signed product is identical to the low half of the full
  // product, so multiplying in the lane width gives the wrapped result.
  assign o_product = i_weight * i_pixel;
`endif

endmodule

// File: rtl/kernel_multiplier.sv
// kernel_multiplier: lane-parallel element-wise multiplier feeding the
// convolver adder tree. KERNEL_SIZE^2 independent lanes, one register stage,
// one operand set accepted per cycle, no backpressure.
// Optional build macro: KERNEL_MULT_SATURATE_EN (saturate instead of wrap).
module kernel_multiplier
  import kernel_mult_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  output logic                                        out_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] result
);

  localparam int N = KERNEL_SIZE * KERNEL_SIZE;

  logic [N*DATA_WIDTH-1:0] w_products;
  logic [N*DATA_WIDTH-1:0] r_result;
  logic                    r_valid;

  // One combinational multiplier per kernel tap; lanes never interact.
  for (genvar g = 0; g < N; g++) begin : g_lane
    mult_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .i_weight  (weights   [g*DATA_WIDTH +: DATA_WIDTH]),
      .i_pixel   (pixel_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_product (w_products[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Output stage: capture products on valid, hold otherwise; reset clears all.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_products;
      end
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_kernel_multiplier.sv
// Directed bench for kernel_multiplier: reset, basic lanes, signed values,
// overflow (wrap or saturate depending on KERNEL_MULT_SATURATE_EN),
// random streaming and reset in the middle of a stream.
module tb_kernel_multiplier;
  import kernel_mult_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int N  = NUM_LANES;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [N*DW-1:0] weights;
  logic [N*DW-1:0] pixel_data;
  logic            out_valid;
  logic [N*DW-1:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kernel_multiplier #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (DEFAULT_KERNEL_SIZE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .weights    (weights),
    .pixel_data (pixel_data),
    .out_valid  (out_valid),
    .result     (result)
  );

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for one lane, computed in 64-bit arithmetic.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    longint maxv;
    longint minv;
    p    = longint'($signed(a)) * longint'($signed(b));
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -(longint'(1) <<< (DW - 1));
`ifdef KERNEL_MULT_SATURATE_EN
    if (p > maxv) p = maxv;
    if (p < minv) p = minv;
`else
    if (p > maxv && p < minv) p = 0;
`endif
    return DW'(p);
  endfunction

  task automatic test_reset();
    reset      = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < N; i++) begin
      weights   [i*DW +: DW] = DW'(i + 11);
      pixel_data[i*DW +: DW] = DW'(5);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid cyc%0d: got %b expected 0", c, out_valid);
      end
      total++;
      if (result !== '0) begin
        bad++;
        $display("FAIL reset_result cyc%0d: got %h expected 0", c, result);
      end
    end
    reset = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_valid: got %b expected 1", out_valid);
    end
    total++;
    if (result[0 +: DW] !== 32'd55 || result[8*DW +: DW] !== 32'd95) begin
      bad++;
      $display("FAIL first_result: got lane0=%h lane8=%h expected 37 5f",
               result[0 +: DW], result[8*DW +: DW]);
    end
  endtask

  task automatic test_basic();
    logic [N*DW-1:0] expected;
    for (int i = 0; i < N; i++) begin
      weights   [i*DW +: DW] = DW'(i + 1);
      pixel_data[i*DW +: DW] = DW'(2);
      expected  [i*DW +: DW] = DW'(2 * (i + 1));
    end
    in_valid = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_valid: got %b expected 1", out_valid);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (result[i*DW +: DW] !== expected[i*DW +: DW]) begin
        bad++;
        $display("FAIL basic_lane%0d: got %h expected %h", i,
                 result[i*DW +: DW], expected[i*DW +: DW]);
      end
    end
    // Idle cycle with different operands: valid drops, result holds.
    in_valid   = 1'b0;
    weights    = {N{32'h1234_5678}};
    pixel_data = {N{32'h0000_0003}};
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_valid: got %b expected 0", out_valid);
    end
    total++;
    if (result !== expected) begin
      bad++;
      $display("FAIL basic_hold: got %h expected %h", result, expected);
    end
  endtask

  task automatic test_signed();
    weights    = '0;
    pixel_data = '0;
    weights   [0 +: DW]  = -32'sd5;
    pixel_data[0 +: DW]  = 32'sd7;
    weights   [DW +: DW] = -32'sd3;
    pixel_data[DW +: DW] = -32'sd4;
    in_valid = 1'b1;
    step();
    total++;
    if (result[0 +: DW] !== 32'hFFFF_FFDD) begin
      bad++;
      $display("FAIL signed_lane0: got %h expected ffffffdd", result[0 +: DW]);
    end
    total++;
    if (result[DW +: DW] !== 32'd12) begin
      bad++;
      $display("FAIL signed_lane1: got %h expected 0000000c", result[DW +: DW]);
    end
    total++;
    if (result[N*DW-1:2*DW] !== '0) begin
      bad++;
      $display("FAIL signed_zero_lanes: got %h expected 0", result[N*DW-1:2*DW]);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
`ifdef KERNEL_MULT_SATURATE_EN
    exp0 = 32'h7FFF_FFFF;
    exp1 = 32'h8000_0000;
`else
    exp0 = 32'h0000_0000;
    exp1 = 32'h0000_0000;
`endif
    weights    = '0;
    pixel_data = '0;
    weights   [0 +: DW]  = 32'h0001_0000;
    pixel_data[0 +: DW]  = 32'h0001_0000;
    weights   [DW +: DW] = 32'h8000_0000;
    pixel_data[DW +: DW] = 32'h0000_0002;
    in_valid = 1'b1;
    step();
    total++;
    if (result[0 +: DW] !== exp0) begin
      bad++;
      $display("FAIL overflow_pos: got %h expected %h", result[0 +: DW], exp0);
    end
    total++;
    if (result[DW +: DW] !== exp1) begin
      bad++;
      $display("FAIL overflow_neg: got %h expected %h", result[DW +: DW], exp1);
    end
  endtask

  task automatic test_stream();
    logic [N*DW-1:0] expected;
    int              errs;
    errs = 0;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < N; i++) begin
        weights   [i*DW +: DW] = $urandom;
        pixel_data[i*DW +: DW] = $urandom;
        expected  [i*DW +: DW] = model(weights[i*DW +: DW], pixel_data[i*DW +: DW]);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || result !== expected) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL stream_%0d: got v=%b %h expected v=1 %h", t, out_valid, result, expected);
      end
    end
    in_valid   = 1'b0;
    weights    = {N{32'h7FFF_0001}};
    pixel_data = {N{32'h0000_0009}};
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_drop_valid: got %b expected 0", out_valid);
    end
    total++;
    if (result !== expected) begin
      bad++;
      $display("FAIL stream_hold: got %h expected %h", result, expected);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1;
    for (int t = 0; t < 2; t++) begin
      weights    = {N{DW'(t + 3)}};
      pixel_data = {N{DW'(4)}};
      step();
    end
    total++;
    if (out_valid !== 1'b1 || result[0 +: DW] !== 32'd16) begin
      bad++;
      $display("FAIL mid_pre: got v=%b lane0=%h expected v=1 00000010", out_valid, result[0 +: DW]);
    end
    // In-flight set arrives together with reset and must be discarded.
    reset      = 1'b1;
    weights    = {N{32'd9}};
    pixel_data = {N{32'd9}};
    step();
    total++;
    if (out_valid !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b %h expected v=0 0", out_valid, result);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL mid_after: got v=%b %h expected v=0 0", out_valid, result);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    weights    = '0;
    pixel_data = '0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_stream();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
